// File: rtl/boot_pkg.sv
// boot_pkg: shared definitions for the boot sequencer.
//   state_t   - frame loader states
//   SYNC_BYTE - default frame start marker
//   MAX_WORDS - largest accepted image size in 16-bit words
//   ADDR_W / DATA_W - instruction memory address and data widths
package boot_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned MAX_WORDS = 32768;
  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned DATA_W    = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/boot_sequencer.sv
// boot_sequencer: loads a program image received as a byte stream into
// instruction memory and releases the CPU once the checksum matches.
// Frame: SYNC, LEN_HI, LEN_LO, N words (high byte first), CHK (XOR of data bytes).
// Ports:
//   clock       - rising-edge clock
//   reset       - synchronous active-low reset
//   rx_data     - received byte
//   rx_valid    - rx_data valid
//   rx_ready    - byte accepted this cycle when rx_valid is high
//   imem_we     - instruction memory write strobe, one cycle per word
//   imem_addr   - instruction memory write address
//   imem_wdata  - instruction memory write data
//   cpu_reset   - active-high reset to the CPU
//   loading     - frame in progress
//   error       - last frame failed; held until the next sync byte
module boot_sequencer
  import boot_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = boot_pkg::SYNC_BYTE,
  parameter int unsigned MAX_WORDS = boot_pkg::MAX_WORDS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [DATA_W-1:0]   imem_wdata,
  output logic                cpu_reset,
  output logic                loading,
  output logic                error
);

  state_t              r_state;
  logic [15:0]         r_len;
  // 16 bits so that a 32768-word image reaches index == N without wrapping
  logic [15:0]         r_index;
  logic [7:0]          r_hi;
  logic [7:0]          r_chk;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_accept;
  logic                w_sync;
  logic [15:0]         w_len_full;
  logic [15:0]         w_index_inc;

  assign w_accept    = rx_valid & rx_ready;
  assign w_sync      = w_accept && (rx_data == SYNC_BYTE);
  assign w_len_full  = {r_len[15:8], rx_data};
  assign w_index_inc = r_index + 16'd1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_index <= '0;
      r_hi    <= '0;
      r_chk   <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        // Sync is only recognised outside a frame; inside one it is data.
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (w_sync) begin
            r_state <= ST_LEN_HI;
            r_chk   <= '0;
            r_index <= '0;
          end
        end
        ST_LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= rx_data;
            r_state     <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= rx_data;
            if (32'(w_len_full) > MAX_WORDS)
              r_state <= ST_ERROR;
            else if (w_len_full == 16'd0)
              r_state <= ST_CHECK;
            else
              r_state <= ST_DATA_HI;
          end
        end
        ST_DATA_HI: begin
          if (w_accept) begin
            r_hi    <= rx_data;
            r_chk   <= r_chk ^ rx_data;
            r_state <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (w_accept) begin
            r_wdata <= {r_hi, rx_data};
            r_chk   <= r_chk ^ rx_data;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_index <= w_index_inc;
          r_state <= (w_index_inc == r_len) ? ST_CHECK : ST_DATA_HI;
        end
        ST_CHECK: begin
          if (w_accept)
            r_state <= (rx_data == r_chk) ? ST_RUN : ST_ERROR;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // All outputs are decodes of registered state, never of rx_*.
  assign rx_ready   = (r_state != ST_WRITE);
  assign imem_we    = (r_state == ST_WRITE);
  assign imem_addr  = r_index[ADDR_W-1:0];
  assign imem_wdata = r_wdata;
  assign cpu_reset  = (r_state != ST_RUN);
  assign error      = (r_state == ST_ERROR);
  assign loading    = (r_state == ST_LEN_HI)  || (r_state == ST_LEN_LO) ||
                      (r_state == ST_DATA_HI) || (r_state == ST_DATA_LO) ||
                      (r_state == ST_WRITE)   || (r_state == ST_CHECK);

endmodule

// File: tb/tb_boot_sequencer.sv
// tb_boot_sequencer: self-checking bench for boot_sequencer. Frames are
// built at frame level (word list + checksum); the expected memory writes
// and release/error outcome follow directly from how each frame was built.
module tb_boot_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [14:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_reset;
  logic        loading;
  logic        error;

  int errors = 0;
  int checks = 0;

  logic [15:0] wq[$];      // words of the frame being sent
  logic [30:0] got_q[$];   // observed writes {addr, data}

  boot_sequencer #(.SYNC_BYTE(8'hA5), .MAX_WORDS(32768)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .loading    (loading),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture writes and check that ready drops exactly during write cycles.
  always @(negedge clock) begin
    if (imem_we === 1'b1) got_q.push_back({imem_addr, imem_wdata});
    check("ready_vs_write", {31'd0, rx_ready}, {31'd0, ~imem_we});
  end

  task automatic send(input logic [7:0] b);
    int unsigned n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!rx_ready && n < 8) begin
      @(negedge clock);
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int unsigned k);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic build_random(input int unsigned n, input bit sync_in_data);
    logic [15:0] w;
    wq.delete();
    for (int unsigned i = 0; i < n; i++) begin
      w = 16'($urandom);
      if (sync_in_data && i == 0) w[15:8] = 8'hA5;
      if (sync_in_data && i == 1) w[7:0]  = 8'hA5;
      wq.push_back(w);
    end
  endtask

  // Sends the frame held in wq and checks the outcome.
  task automatic run_frame(input bit bad, input bit gaps, input bit skip_sync);
    logic [7:0]  chk;
    logic [15:0] n;
    chk = 8'h00;
    foreach (wq[i]) chk = chk ^ wq[i][15:8] ^ wq[i][7:0];
    n = 16'(wq.size());
    got_q.delete();
    if (!skip_sync) send(8'hA5);
    send(n[15:8]);
    send(n[7:0]);
    foreach (wq[i]) begin
      send(wq[i][15:8]);
      if (gaps) idle($urandom_range(0, 2));
      send(wq[i][7:0]);
      if (gaps) idle($urandom_range(0, 2));
    end
    check("loading_before_chk", {31'd0, loading}, 32'd1);
    check("held_before_chk", {31'd0, cpu_reset}, 32'd1);
    send(bad ? (chk ^ 8'($urandom_range(1, 255))) : chk);
    rx_valid = 1'b0;
    check("cpu_reset_after_chk", {31'd0, cpu_reset}, {31'd0, bad});
    check("error_after_chk", {31'd0, error}, {31'd0, bad});
    check("loading_after_chk", {31'd0, loading}, 32'd0);
    check("write_count", got_q.size(), 32'(wq.size()));
    foreach (got_q[i]) begin
      if (i < wq.size()) begin
        check("write_addr", {17'd0, got_q[i][30:16]}, i);
        check("write_data", {16'd0, got_q[i][15:0]}, {16'd0, wq[i]});
      end
    end
  endtask

  task automatic check_reset_values();
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_imem_addr", {17'd0, imem_addr}, 32'd0);
    check("rst_imem_wdata", {16'd0, imem_wdata}, 32'd0);
    check("rst_loading", {31'd0, loading}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values();
    reset = 1'b1;
    idle(2);

    // Directed two-word frame
    wq = '{16'h1234, 16'hABCD};
    run_frame(1'b0, 1'b1, 1'b0);

    // Same frame with a wrong checksum, then a good frame clears error
    wq = '{16'h1234, 16'hABCD};
    run_frame(1'b1, 1'b0, 1'b0);
    idle(3);
    check("error_sticky", {31'd0, error}, 32'd1);
    check("held_after_error", {31'd0, cpu_reset}, 32'd1);
    wq = '{16'h1234, 16'hABCD};
    run_frame(1'b0, 1'b0, 1'b0);

    // Empty image releases with CHK 00
    wq.delete();
    run_frame(1'b0, 1'b0, 1'b0);

    // Oversize length aborts straight after LEN_LO
    got_q.delete();
    send(8'hA5);
    send(8'h80);
    send(8'h01);
    rx_valid = 1'b0;
    check("oversize_error", {31'd0, error}, 32'd1);
    check("oversize_held", {31'd0, cpu_reset}, 32'd1);
    check("oversize_loading", {31'd0, loading}, 32'd0);
    idle(3);
    check("oversize_writes", got_q.size(), 32'd0);

    // Continuous valid, with sync bytes inside the data
    build_random(5, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0);

    // In RUN: non-sync ignored, sync restarts
    send(8'h55);
    rx_valid = 1'b0;
    check("run_ignore_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("run_ignore_loading", {31'd0, loading}, 32'd0);
    idle(2);
    send(8'hA5);
    rx_valid = 1'b0;
    check("restart_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("restart_loading", {31'd0, loading}, 32'd1);
    build_random(3, 1'b1);
    run_frame(1'b0, 1'b1, 1'b1);

    // Reset after the first word of a frame is written
    build_random(3, 1'b0);
    got_q.delete();
    send(8'hA5);
    send(8'h00);
    send(8'h03);
    send(wq[0][15:8]);
    send(wq[0][7:0]);
    idle(2);
    check("partial_writes", got_q.size(), 32'd1);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_reset_values();
    reset = 1'b1;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    idle(3);
    check("post_reset_held", {31'd0, cpu_reset}, 32'd1);
    check("post_reset_loading", {31'd0, loading}, 32'd0);
    check("post_reset_writes", got_q.size(), 32'd1);
    wq = '{16'hBEEF, 16'h0001, 16'hA5A5};
    run_frame(1'b0, 1'b0, 1'b0);

    // Random frames, random gaps, some corrupted
    repeat (8) begin
      build_random($urandom_range(1, 6), 1'($urandom_range(0, 1)));
      run_frame($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'b0);
      idle($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
